// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_pkg: shared types and widths for the Wishbone command master.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int WB_AW = 30;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

endpackage
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_cmd_master: single-outstanding pipelined Wishbone initiator     |
// | with valid/ready command/response streams and a bus timeout.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int TIMEOUT = 1023
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_we,
  input  logic [AW-1:0]    i_cmd_addr,
  input  logic [WB_DW-1:0] i_cmd_data,
  input  logic [WB_SW-1:0] i_cmd_sel,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WB_DW-1:0] o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [AW-1:0]    o_wb_addr,
  output logic [WB_DW-1:0] o_wb_data,
  output logic [WB_SW-1:0] o_wb_sel,
  input  logic             i_wb_stall,
  input  logic             i_wb_ack,
  input  logic             i_wb_err,
  input  logic [WB_DW-1:0] i_wb_data,
  output logic             o_busy
);

  localparam int             c_tw        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_tw-1:0] c_timer_max = {c_tw{1'b1}};
  localparam logic [c_tw-1:0] c_timeout   = c_tw'(TIMEOUT);

  state_t             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [WB_DW-1:0]   wdata_q, wdata_d;
  logic [WB_SW-1:0]   sel_q, sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WB_DW-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic [c_tw-1:0]    timer_q, timer_d;

  logic [c_tw-1:0]    w_timer_inc;
  logic               w_expired;

  // Timer value including the current cycle; expiry fires in the TIMEOUT-th bus cycle.
  assign w_timer_inc = (timer_q == c_timer_max) ? timer_q : timer_q + 1'b1;
  assign w_expired   = (TIMEOUT != 0) && (w_timer_inc == c_timeout);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    timer_d     = timer_q;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          state_d = ST_REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_data;
          sel_d   = i_cmd_sel;
          timer_d = '0;
        end
      end
      ST_REQ, ST_WAIT: begin
        timer_d = w_timer_inc;
        if (i_wb_err || i_wb_ack) begin
          // err wins over ack; writes and errors never return bus data
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = i_wb_err;
          rsp_data_d  = (!i_wb_err && !we_q) ? i_wb_data : '0;
        end else if (w_expired) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else if (state_q == ST_REQ && !i_wb_stall) begin
          state_d = ST_WAIT;
          stb_d   = 1'b0;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      timer_q     <= timer_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = wdata_q;
  assign o_wb_sel    = sel_q;
  assign o_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb_cmd_master: self-checking bench for wb_cmd_master.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_wb_cmd_master;

  localparam int AW = 30;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_data = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_ready = 1'b1;
  logic          wb_stall = 1'b0;
  logic          wb_ack = 1'b0;
  logic          wb_err = 1'b0;
  logic [31:0]   wb_rdata = '0;

  logic          o_cmd_ready, o_rsp_valid, o_rsp_err;
  logic [31:0]   o_rsp_data;
  logic          o_wb_cyc, o_wb_stb, o_wb_we, o_busy;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;

  wb_cmd_master #(.AW(AW), .TIMEOUT(TO)) u_dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_we(cmd_we), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_sel(cmd_sel),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .i_wb_data(wb_rdata), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding bus request, a bus age in cycles,
  // and a single-entry response slot.
  logic          m_cyc, m_stb, m_we, m_rsp_valid, m_rsp_err, m_cmd_ready, m_busy;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rsp_data;
  logic [3:0]    m_sel;
  int            m_age;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc <= 0; m_stb <= 0; m_we <= 0; m_addr <= '0; m_wdata <= '0; m_sel <= '0;
      m_rsp_valid <= 0; m_rsp_err <= 0; m_rsp_data <= '0;
      m_cmd_ready <= 1; m_busy <= 0; m_age <= 0;
    end else if (m_rsp_valid) begin
      if (rsp_ready) begin
        m_rsp_valid <= 0; m_rsp_err <= 0; m_rsp_data <= '0;
        m_cmd_ready <= 1; m_busy <= 0;
      end
    end else if (m_cyc) begin
      m_age <= m_age + 1;
      if (wb_err || wb_ack) begin
        m_cyc <= 0; m_stb <= 0; m_rsp_valid <= 1;
        m_rsp_err  <= wb_err;
        m_rsp_data <= (wb_err || m_we) ? 32'h0 : wb_rdata;
      end else if (m_age + 1 == TO) begin
        m_cyc <= 0; m_stb <= 0; m_rsp_valid <= 1; m_rsp_err <= 1; m_rsp_data <= '0;
      end else if (!wb_stall) begin
        m_stb <= 0;
      end
    end else if (m_cmd_ready && cmd_valid) begin
      m_cyc <= 1; m_stb <= 1; m_we <= cmd_we; m_addr <= cmd_addr;
      m_wdata <= cmd_data; m_sel <= cmd_sel; m_age <= 0;
      m_cmd_ready <= 0; m_busy <= 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", o_cmd_ready, m_cmd_ready);
      check("busy",      o_busy,      m_busy);
      check("rsp_valid", o_rsp_valid, m_rsp_valid);
      if (m_rsp_valid) begin
        check("rsp_data", o_rsp_data, m_rsp_data);
        check("rsp_err",  o_rsp_err,  m_rsp_err);
      end
      check("wb_cyc", o_wb_cyc, m_cyc);
      check("wb_stb", o_wb_stb, m_stb);
      if (m_cyc) begin
        check("wb_we",   o_wb_we,   m_we);
        check("wb_addr", o_wb_addr, m_addr);
        check("wb_data", o_wb_data, m_wdata);
        check("wb_sel",  o_wb_sel,  m_sel);
      end
    end
  end

  int stb_cnt = 0;
  int cyc_cnt = 0;
  always @(posedge clk) begin
    stb_cnt <= stb_cnt + (o_wb_stb ? 1 : 0);
    cyc_cnt <= cyc_cnt + (o_wb_cyc ? 1 : 0);
  end

  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] data, input logic [3:0] sel);
    int k;
    @(negedge clk);
    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_sel = sel;
    k = 0;
    while (!o_cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("accept_wait_expired", 1, 0);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int nstall, input int nwait,
                         input logic ack, input logic err, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_stb, input int exp_cyc);
    int s_stb, s_cyc;
    s_stb = stb_cnt; s_cyc = cyc_cnt;
    issue(we, addr, wdata, sel);
    for (int i = 0; i < nstall; i++) begin
      wb_stall = 1;
      @(negedge clk);
    end
    wb_stall = 0;
    repeat (nwait) @(negedge clk);
    wb_ack = ack; wb_err = err; wb_rdata = rdata;
    @(negedge clk);
    wb_ack = 0; wb_err = 0;
    check("rsp_valid_after_ack", o_rsp_valid, 1);
    check("rsp_data_lit", o_rsp_data, exp_data);
    check("rsp_err_lit", o_rsp_err, exp_err);
    check("cyc_dropped", o_wb_cyc, 0);
    check("stb_cycles", stb_cnt - s_stb, exp_stb);
    check("cyc_cycles", cyc_cnt - s_cyc, exp_cyc);
  endtask

  initial begin
    #400000;
    $display("FAIL global_watchdog: got stuck expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_cyc;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("reset_cmd_ready", o_cmd_ready, 1);
    check("reset_cyc", o_wb_cyc, 0);
    check("reset_rsp_valid", o_rsp_valid, 0);
    check("reset_busy", o_busy, 0);
    rst = 0;
    @(negedge clk);

    // zero-wait write
    run_txn(1, 30'h0, 32'h0001_0001, 4'hF, 0, 0, 1, 0, 32'h0, 32'h0, 0, 1, 1);
    // stalled read: 3 stall cycles, ack two cycles after stall drops
    run_txn(0, 30'h10, 32'h0, 4'hF, 3, 2, 1, 0, 32'hABCD_1234, 32'hABCD_1234, 0, 4, 6);
    // ack and err together: err wins
    run_txn(0, 30'h5, 32'h0, 4'hF, 0, 0, 1, 1, 32'hDEAD_BEEF, 32'h0, 1, 1, 1);
    // further directed vectors
    run_txn(1, 30'h3FFF_FFFF, 32'hFFFF_FFFF, 4'h1, 0, 3, 0, 1, 32'h0, 32'h0, 1, 1, 4);
    run_txn(0, 30'h2A, 32'h0, 4'h6, 1, 0, 1, 0, 32'h5555_AAAA, 32'h5555_AAAA, 0, 2, 2);
    run_txn(1, 30'h7, 32'h1234_5678, 4'hC, 2, 1, 1, 0, 32'hFFFF_FFFF, 32'h0, 0, 3, 4);

    // timeout: no ack, late ack ignored
    s_cyc = cyc_cnt;
    issue(0, 30'h99, 32'h0, 4'hF);
    repeat (TO) @(negedge clk);
    check("to_rsp_valid", o_rsp_valid, 1);
    check("to_rsp_err", o_rsp_err, 1);
    check("to_rsp_data", o_rsp_data, 0);
    check("to_cyc_cycles", cyc_cnt - s_cyc, TO);
    repeat (3) @(negedge clk);
    wb_ack = 1; wb_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    wb_ack = 0;
    check("late_ack_busy", o_busy, 0);
    check("late_ack_cyc", o_wb_cyc, 0);
    check("late_ack_rsp", o_rsp_valid, 0);

    // response backpressure with a second command waiting
    rsp_ready = 0;
    issue(1, 30'h20, 32'h11, 4'h3);
    cmd_valid = 1; cmd_we = 1; cmd_addr = 30'h21; cmd_data = 32'h22; cmd_sel = 4'hC;
    wb_ack = 1;
    @(negedge clk);
    wb_ack = 0;
    check("bp_rsp_valid", o_rsp_valid, 1);
    s_cyc = cyc_cnt;
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", o_cmd_ready, 0);
      check("bp_no_cyc", o_wb_cyc, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    check("bp_ready_after", o_cmd_ready, 1);
    check("bp_no_cyc_total", cyc_cnt - s_cyc, 0);
    @(negedge clk);
    cmd_valid = 0;
    check("bp_second_cyc", o_wb_cyc, 1);
    check("bp_second_addr", o_wb_addr, 30'h21);
    wb_ack = 1;
    @(negedge clk);
    wb_ack = 0;
    check("bp_second_rsp", o_rsp_valid, 1);

    // reset in WAIT
    issue(0, 30'h44, 32'h0, 4'hF);
    @(negedge clk);
    check("rst_in_wait_cyc", o_wb_cyc, 1);
    check("rst_in_wait_stb", o_wb_stb, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    rst = 0;
    @(negedge clk);
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Single-outstanding Wishbone (pipelined, B4) bus initiator. It turns a valid/ready command stream into one bus transaction at a time and returns read data or error on a valid/ready response stream. It sits between a sequencer or debug bridge and the peripheral bus, e.g. driving wbgpio-style registers (set/clear writes, status reads). It has a bus timeout so a dead or unmapped slave cannot hang the command source.

Parameters:
AW, 30, Wishbone word-address width.
TIMEOUT, 1023, max cycles from first stb to ack/err before abort; 0 disables timeout.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_we  in  1  1=write, 0=read
i_cmd_addr  in  AW  word address
i_cmd_data  in  32  write data
i_cmd_sel  in  4  byte selects
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  response consumed when valid&ready
o_rsp_data  out  32  read data (0 for writes/errors)
o_rsp_err  out  1  bus error or timeout
o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  bus control
o_wb_addr  out  AW;  o_wb_data  out  32;  o_wb_sel  out  4
i_wb_stall, i_wb_ack, i_wb_err  in  1 each
i_wb_data  in  32  slave read data
o_busy  out  1  state != IDLE

Behaviour:
- One clock (i_clk); reset is synchronous, active-high (i_reset). All bus and handshake signals are registered. Reset values are 0 for every output except o_cmd_ready, which is 1 (IDLE, response empty).
- States: IDLE, REQ, WAIT, RESP.
- IDLE: o_cmd_ready = (state==IDLE) && !o_rsp_valid. On accept, latch we/addr/data/sel onto o_wb_*, set cyc=stb=1, clear timer, go to REQ.
- REQ: stb held until a cycle with !i_wb_stall. In that cycle stb drops next edge.
  - ack/err sampled in the same cycle goes straight to RESP.
  - Otherwise go to WAIT (cyc=1, stb=0).
- WAIT: hold cyc until i_wb_ack or i_wb_err.
- Completion: next edge cyc=0, o_rsp_valid=1. Read ack: o_rsp_data=i_wb_data, err=0. Write ack: data=0, err=0. err: data=0, err=1.
- err has priority over ack if both are asserted.
- Timer counts every cycle in REQ/WAIT, saturating. If TIMEOUT!=0 and the timer reaches TIMEOUT with no ack/err: drop cyc and stb, respond err=1, data=0. Timer width = clog2(TIMEOUT+1).
- RESP: o_rsp_valid and data/err are stable until i_rsp_ready, then IDLE. The next command can be accepted the cycle after the handshake.
- Zero-wait slave latency: cmd accept edge 0 → cyc/stb at cycle 1 → ack at cycle 1 → rsp_valid at cycle 2. Minimum 3 cycles per command back-to-back.
- Stray ack/err in IDLE or RESP are ignored. ack arriving after a timeout abort is ignored.
- o_wb_addr/data/sel/we hold their last values when cyc=0 (don't-care to slaves; keep stable to save toggles).
- i_reset mid-transaction: next edge cyc=stb=0, state IDLE, any pending response discarded (o_rsp_valid=0).
- i_cmd_valid while not ready: the command is not consumed. The source must hold it (standard valid/ready).

Decomposition:
- Shared package wb_pkg: state enumeration (IDLE/REQ/WAIT/RESP), default AW=30, data width 32, sel width 4.
- No sub-module. The timeout counter is inline. The FSM plus registers fit one module of roughly 150-200 lines.

Test Plan:
- Zero-wait write: cmd we=1, addr=0, data=0x0001_0001, sel=0xF; slave acks with stb → one cyc/stb cycle with those values, rsp_valid at cycle 2, err=0, data=0.
- Stalled read: stall=1 for 3 cycles, ack 2 cycles after stall drops with i_wb_data=0xABCD_1234 → stb high exactly 4 cycles, cyc continuous, rsp_data=0xABCD_1234.
- Bus error: read, slave asserts err and ack together → rsp_err=1, rsp_data=0, cyc dropped next edge.
- Timeout: TIMEOUT=8, slave never acks → cyc drops after 8 cycles in REQ/WAIT, rsp_err=1; late ack at cycle 12 ignored, state IDLE.
- Backpressure: i_rsp_ready=0 for 5 cycles with a second cmd waiting → o_cmd_ready=0 and no second cyc until the response handshake; second cmd issues after.
- Reset mid-WAIT: i_reset pulse while cyc=1 → cyc=stb=0 and rsp_valid=0 next edge, o_cmd_ready=1 after reset deasserts.
